sram2s_arbiter: RTL and testbench

- Shares one dual-port 128x16 SRAM (two CE/A/D/WE/WEM/Q port sets, 1-cycle synchronous read) among NREQ requesters.
- Each cycle it grants up to two requests, one per SRAM port, using round-robin priority.
- It blocks same-address hazards between the two ports and returns read data to the originating requester with a fixed latency.
- It sits between the RBM compute engines and the shared weight/visible-unit SRAM.

---
 rtl/sram2s_arb_pkg.sv | 45 ++++
 rtl/sram2s_arbiter_rr_pick2.sv | 74 +++++++
 rtl/sram2s_arbiter.sv | 144 ++++++++++++++
 tb/tb_sram2s_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram2s_arb_pkg.sv
// Shared types and the round-robin search helper for the dual-port SRAM arbiter.
// Tags and picks are sized for the largest supported requester count (8).
package sram2s_arb_pkg;

    localparam int AW_DEF   = 7;
    localparam int DW_DEF   = 16;
    localparam int NREQ_MAX = 8;
    localparam int IDXW     = 3;

    typedef struct packed {
        logic            valid;
        logic [IDXW-1:0] idx;
    } tag_t;

    typedef struct packed {
        logic            found;
        logic [IDXW-1:0] idx;
    } pick_t;

    // First requester at or after ptr (wrapping at nreq) that is requesting and not excluded.
    function automatic pick_t rr_pick(
        input logic [NREQ_MAX-1:0] req_mask,
        input logic [IDXW-1:0]     ptr,
        input logic [IDXW:0]       nreq,
        input logic [NREQ_MAX-1:0] exclude
    );
        pick_t         r;
        logic [IDXW:0] offv;
        logic [IDXW:0] cand;
        r = '0;
        for (int off = NREQ_MAX - 1; off >= 0; off--) begin
            offv = (IDXW + 1)'(off);
            cand = {1'b0, ptr} + offv;
            if (cand >= nreq) begin
                cand = cand - nreq;
            end
            if ((offv < nreq) && req_mask[cand[IDXW-1:0]] && !exclude[cand[IDXW-1:0]]) begin
                r.found = 1'b1;
                r.idx   = cand[IDXW-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sram2s_arbiter_rr_pick2.sv
// Combinational dual round-robin pick: port 0 gets the first requester from the
// pointer, port 1 the next distinct one unless it collides with port 0 on an address.
module rr_pick2
    import sram2s_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = AW_DEF
) (
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ-1:0]    i_we,
    input  logic [NREQ*AW-1:0] i_addr,
    input  logic [IDXW-1:0]    i_ptr,
    output pick_t              o_pick0,
    output pick_t              o_pick1,
    output logic [NREQ-1:0]    o_gnt
);

    localparam logic [IDXW:0] NREQ_L = (IDXW + 1)'(NREQ);

    logic [NREQ_MAX-1:0] w_req_ext;
    logic [NREQ_MAX-1:0] w_excl;
    pick_t               w_p0;
    pick_t               w_p1_raw;
    logic [AW-1:0]       w_a0;
    logic [AW-1:0]       w_a1;
    logic                w_we0;
    logic                w_we1;
    logic                w_hazard;

    assign w_req_ext = NREQ_MAX'(i_req);
    assign w_p0      = rr_pick(w_req_ext, i_ptr, NREQ_L, '0);

    always_comb begin
        w_excl            = '0;
        w_excl[w_p0.idx]  = w_p0.found;
    end

    assign w_p1_raw = rr_pick(w_req_ext, i_ptr, NREQ_L, w_excl);

    always_comb begin
        w_a0  = '0;
        w_a1  = '0;
        w_we0 = 1'b0;
        w_we1 = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_p0.idx == IDXW'(i)) begin
                w_a0  = i_addr[i*AW +: AW];
                w_we0 = i_we[i];
            end
            if (w_p1_raw.idx == IDXW'(i)) begin
                w_a1  = i_addr[i*AW +: AW];
                w_we1 = i_we[i];
            end
        end
    end

    // A same-address pair involving a write would race inside the SRAM; port 1 retries.
    assign w_hazard = w_p0.found && w_p1_raw.found && (w_a0 == w_a1) && (w_we0 || w_we1);

    always_comb begin
        o_pick0       = w_p0;
        o_pick1       = w_p1_raw;
        o_pick1.found = w_p1_raw.found && !w_hazard;
    end

    always_comb begin
        o_gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            o_gnt[i] = (o_pick0.found && (o_pick0.idx == IDXW'(i))) ||
                       (o_pick1.found && (o_pick1.idx == IDXW'(i)));
        end
    end

endmodule

// File: rtl/sram2s_arbiter.sv
// Round-robin arbiter sharing one dual-port SRAM among NREQ requesters.
// Registers the SRAM issue and routes read data back two cycles after the grant.
module sram2s_arbiter
    import sram2s_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    REQ,
    input  logic [NREQ-1:0]    REQ_WE,
    input  logic [NREQ*AW-1:0] REQ_ADDR,
    input  logic [NREQ*DW-1:0] REQ_WDATA,
    output logic [NREQ-1:0]    GNT,
    output logic [NREQ-1:0]    RVALID,
    output logic [DW-1:0]      RDATA,
    output logic [DW-1:0]      RDATA1,
    output logic [NREQ-1:0]    RPORT,
    output logic               CE0,
    output logic               CE1,
    output logic [AW-1:0]      A0,
    output logic [AW-1:0]      A1,
    output logic [DW-1:0]      D0,
    output logic [DW-1:0]      D1,
    output logic               WE0,
    output logic               WE1,
    output logic [DW-1:0]      WEM0,
    output logic [DW-1:0]      WEM1,
    input  logic [DW-1:0]      Q0,
    input  logic [DW-1:0]      Q1
);

    pick_t           w_pick [2];
    logic [NREQ-1:0] w_gnt;
    logic [IDXW-1:0] r_ptr;
    logic [IDXW-1:0] w_last;
    logic [IDXW-1:0] w_ptr_nxt;
    logic [AW-1:0]   w_addr [2];
    logic [DW-1:0]   w_wdata [2];
    logic            w_we [2];

    logic            r_ce [2];
    logic [AW-1:0]   r_a [2];
    logic [DW-1:0]   r_d [2];
    logic            r_we [2];
    tag_t            r_tag_s1 [2];
    tag_t            r_tag_s2 [2];

    rr_pick2 #(
        .NREQ (NREQ),
        .AW   (AW)
    ) u_pick (
        .i_req   (REQ),
        .i_we    (REQ_WE),
        .i_addr  (REQ_ADDR),
        .i_ptr   (r_ptr),
        .o_pick0 (w_pick[0]),
        .o_pick1 (w_pick[1]),
        .o_gnt   (w_gnt)
    );

    assign GNT = RST ? '0 : w_gnt;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_addr[p]  = '0;
            w_wdata[p] = '0;
            w_we[p]    = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (w_pick[p].idx == IDXW'(i)) begin
                    w_addr[p]  = REQ_ADDR[i*AW +: AW];
                    w_wdata[p] = REQ_WDATA[i*DW +: DW];
                    w_we[p]    = REQ_WE[i];
                end
            end
        end
    end

    // Port 1 is only ever granted alongside port 0, so it is the later one when present.
    assign w_last    = w_pick[1].found ? w_pick[1].idx : w_pick[0].idx;
    assign w_ptr_nxt = (w_last == IDXW'(NREQ - 1)) ? '0 : w_last + 1'b1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ptr <= '0;
        end else if (w_pick[0].found) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int p = 0; p < 2; p++) begin
                r_ce[p]     <= 1'b0;
                r_a[p]      <= '0;
                r_d[p]      <= '0;
                r_we[p]     <= 1'b0;
                r_tag_s1[p] <= '0;
                r_tag_s2[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_ce[p] <= w_pick[p].found;
                r_we[p] <= w_pick[p].found && w_we[p];
                if (w_pick[p].found) begin
                    r_a[p] <= w_addr[p];
                    r_d[p] <= w_wdata[p];
                end
                r_tag_s1[p].valid <= w_pick[p].found && !w_we[p];
                r_tag_s1[p].idx   <= w_pick[p].idx;
                r_tag_s2[p]       <= r_tag_s1[p];
            end
        end
    end

    always_comb begin
        RVALID = '0;
        RPORT  = '0;
        for (int i = 0; i < NREQ; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (r_tag_s2[p].valid && (r_tag_s2[p].idx == IDXW'(i))) begin
                    RVALID[i] = 1'b1;
                    RPORT[i]  = 1'(p);
                end
            end
        end
    end

    assign RDATA  = Q0;
    assign RDATA1 = Q1;
    assign CE0    = r_ce[0];
    assign CE1    = r_ce[1];
    assign A0     = r_a[0];
    assign A1     = r_a[1];
    assign D0     = r_d[0];
    assign D1     = r_d[1];
    assign WE0    = r_we[0];
    assign WE1    = r_we[1];
    assign WEM0   = '1;
    assign WEM1   = '1;

endmodule

// File: tb/tb_sram2s_arbiter.sv
// Bench for sram2s_arbiter: behavioural SRAM, grant/response reference model,
// a grant table, directed corner sequences and a randomized phase.
module tb_sram2s_arbiter;

    localparam int N  = 4;
    localparam int AW = 7;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt, rvalid, rport;
    logic [DW-1:0]   rdata, rdata1;
    logic            ce0, ce1, we0, we1;
    logic [AW-1:0]   a0, a1;
    logic [DW-1:0]   d0, d1, wem0, wem1, q0, q1;

    always #5 clk = ~clk;

    sram2s_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
        .CLK(clk), .RST(rst), .REQ(req), .REQ_WE(req_we), .REQ_ADDR(req_addr),
        .REQ_WDATA(req_wdata), .GNT(gnt), .RVALID(rvalid), .RDATA(rdata),
        .RDATA1(rdata1), .RPORT(rport), .CE0(ce0), .CE1(ce1), .A0(a0), .A1(a1),
        .D0(d0), .D1(d1), .WE0(we0), .WE1(we1), .WEM0(wem0), .WEM1(wem1),
        .Q0(q0), .Q1(q1)
    );

    function automatic logic [15:0] init_val(input logic [6:0] a);
        return {a, 1'b1, a, 1'b0} ^ 16'h5A5A;
    endfunction

    // Behavioural dual-port SRAM with 1-cycle synchronous read
    logic [DW-1:0] sram [128];
    logic [127:0]  sram_wr = '0;
    always @(posedge clk) begin
        if (ce0) begin
            if (we0) begin sram[a0] <= d0; sram_wr[a0] <= 1'b1; end
            else q0 <= sram_wr[a0] ? sram[a0] : init_val(a0);
        end
        if (ce1) begin
            if (we1) begin sram[a1] <= d1; sram_wr[a1] <= 1'b1; end
            else q1 <= sram_wr[a1] ? sram[a1] : init_val(a1);
        end
    end

    // Reference model state
    int            errors = 0, checks = 0, cyc = 0, m_ptr = 0;
    logic [DW-1:0] ref_mem [128];
    logic [N-1:0]  sl_rv [4];
    logic [N-1:0]  sl_port [4];
    logic [DW-1:0] sl_data [4][N];
    logic [N-1:0]  last_gnt, act_gnt;

    typedef struct {
        logic [N-1:0]    req;
        logic [N-1:0]    we;
        logic [N*AW-1:0] addr;
        logic [N-1:0]    gnt;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [6:0] a, input logic [15:0] d);
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_model();
        for (int s = 0; s < 4; s++) begin sl_rv[s] = '0; sl_port[s] = '0; end
        m_ptr = 0;
    endtask

    task automatic model_pick(output int p0, output int p1);
        p0 = -1; p1 = -1;
        for (int off = 0; off < N; off++) begin
            int i;
            i = (m_ptr + off) % N;
            if (req[i]) begin
                if (p0 < 0) p0 = i;
                else if (p1 < 0) p1 = i;
            end
        end
        if (p1 >= 0 && req_addr[p0*AW +: AW] == req_addr[p1*AW +: AW] && (req_we[p0] || req_we[p1]))
            p1 = -1;
    endtask

    task automatic accept(input int i, input int port, input int sn);
        logic [6:0] a;
        a = req_addr[i*AW +: AW];
        if (req_we[i]) ref_mem[a] = req_wdata[i*DW +: DW];
        else begin
            sl_rv[sn][i]   = 1'b1;
            sl_port[sn][i] = (port == 1);
            sl_data[sn][i] = ref_mem[a];
        end
    endtask

    // One clock cycle: checks grants and due responses at the negedge, then advances.
    task automatic cycle(input logic [N-1:0] exp_gnt, input bit use_exp);
        int p0, p1, s, sn;
        logic [N-1:0] mg;
        @(negedge clk);
        model_pick(p0, p1);
        mg = '0;
        if (p0 >= 0) mg[p0] = 1'b1;
        if (p1 >= 0) mg[p1] = 1'b1;
        act_gnt  = gnt;
        last_gnt = mg;
        chk("gnt_model", gnt, mg);
        if (use_exp) chk("gnt_table", gnt, exp_gnt);
        s = cyc % 4;
        chk("rvalid", rvalid, sl_rv[s]);
        for (int i = 0; i < N; i++) begin
            if (sl_rv[s][i]) begin
                chk("rport", rport[i], sl_port[s][i]);
                chk("rdata", sl_port[s][i] ? rdata1 : rdata, sl_data[s][i]);
            end
        end
        sl_rv[s] = '0;
        sn = (cyc + 2) % 4;
        if (p0 >= 0) accept(p0, 0, sn);
        if (p1 >= 0) accept(p1, 1, sn);
        if (p1 >= 0) m_ptr = (p1 + 1) % N;
        else if (p0 >= 0) m_ptr = (p0 + 1) % N;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int tally [N];
        int wait_c [N];
        int max_wait;
        for (int a = 0; a < 128; a++) ref_mem[a] = init_val(7'(a));
        clear_model();
        req = '1; req_we = '0; req_addr = '0; req_wdata = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ce0", ce0, 0);
        chk("rst_ce1", ce1, 0);
        chk("rst_we0", we0, 0);
        chk("rst_a0", a0, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_gnt", gnt, 0);
        chk("wem0", wem0, 16'hFFFF);
        chk("wem1", wem1, 16'hFFFF);
        req = '0;
        rst = 1'b0;

        // Grant table from pointer 0
        tbl[0] = '{4'b1111, 4'b0000, {7'h23, 7'h22, 7'h21, 7'h20}, 4'b0011};
        tbl[1] = '{4'b1111, 4'b0000, {7'h23, 7'h22, 7'h21, 7'h20}, 4'b1100};
        tbl[2] = '{4'b0100, 4'b0000, {7'h23, 7'h22, 7'h21, 7'h20}, 4'b0100};
        tbl[3] = '{4'b1001, 4'b0000, {7'h23, 7'h22, 7'h21, 7'h20}, 4'b1001};
        tbl[4] = '{4'b0011, 4'b0001, {7'h23, 7'h22, 7'h10, 7'h10}, 4'b0010};
        tbl[5] = '{4'b0000, 4'b0000, {7'h23, 7'h22, 7'h21, 7'h20}, 4'b0000};
        tbl[6] = '{4'b0011, 4'b0000, {7'h23, 7'h22, 7'h30, 7'h30}, 4'b0011};
        tbl[7] = '{4'b1000, 4'b1000, {7'h23, 7'h22, 7'h21, 7'h20}, 4'b1000};
        req_wdata = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        for (int k = 0; k < 8; k++) begin
            req = tbl[k].req; req_we = tbl[k].we; req_addr = tbl[k].addr;
            cycle(tbl[k].gnt, 1'b1);
        end
        req = '0;
        repeat (2) cycle('0, 1'b0);

        // Single read of a preloaded location
        set_req(2, 1'b1, 7'h05, 16'hBEEF); req = 4'b0100;
        cycle(4'b0100, 1'b1);
        req = '0;
        cycle('0, 1'b0);
        set_req(2, 1'b0, 7'h05, 16'h0000); req = 4'b0100;
        cycle(4'b0100, 1'b1);
        chk("single_ce0", ce0, 1);
        chk("single_a0", a0, 7'h05);
        req = '0;
        cycle('0, 1'b0);
        chk("single_rvalid2", rvalid[2], 1);
        chk("single_rdata", rdata, 16'hBEEF);
        chk("single_rport2", rport[2], 0);
        cycle('0, 1'b0);

        // Reset with a read in flight
        set_req(0, 1'b0, 7'h05, 16'h0000); req = 4'b0001;
        cycle(4'b0001, 1'b1);
        req = '1;
        rst = 1'b1;
        #1;
        chk("midrst_ce0", ce0, 0);
        chk("midrst_ce1", ce1, 0);
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_gnt", gnt, 0);
        clear_model();
        @(posedge clk); #1;
        chk("midrst_rvalid_late", rvalid, 0);
        req = '0;
        rst = 1'b0;

        // Fairness: everyone reads continuously
        for (int i = 0; i < N; i++) begin set_req(i, 1'b0, 7'(7'h60 + i), 16'h0); tally[i] = 0; end
        req = '1;
        for (int c = 0; c < 8; c++) begin
            cycle((c % 2 == 0) ? 4'b0011 : 4'b1100, 1'b1);
            for (int i = 0; i < N; i++) if (act_gnt[i]) tally[i]++;
        end
        for (int i = 0; i < N; i++) chk("fair_count", tally[i], 4);
        req = '0;
        repeat (2) cycle('0, 1'b0);

        // Write/read hazard on the same address
        set_req(0, 1'b1, 7'h10, 16'h1234);
        set_req(1, 1'b0, 7'h10, 16'h0000);
        req = 4'b0011;
        cycle(4'b0001, 1'b1);
        req = 4'b0010;
        cycle(4'b0010, 1'b1);
        req = '0;
        cycle('0, 1'b0);
        chk("haz_rvalid", rvalid, 4'b0010);
        chk("haz_rdata", rdata, 16'h1234);
        cycle('0, 1'b0);

        // Two reads of the same address share the cycle
        set_req(0, 1'b0, 7'h7F, 16'h0);
        set_req(3, 1'b0, 7'h7F, 16'h0);
        req = 4'b1001;
        cycle(4'b1001, 1'b1);
        req = '0;
        cycle('0, 1'b0);
        chk("same_rvalid", rvalid, 4'b1001);
        chk("same_rport", rport & rvalid, 4'b0001);
        chk("same_lane0", rdata, init_val(7'h7F));
        chk("same_lane1", rdata1, init_val(7'h7F));
        cycle('0, 1'b0);

        // Write then read next cycle
        set_req(1, 1'b1, 7'h00, 16'hA5A5); req = 4'b0010;
        cycle(4'b0010, 1'b1);
        set_req(1, 1'b0, 7'h00, 16'h0000);
        cycle(4'b0010, 1'b1);
        req = '0;
        cycle('0, 1'b0);
        chk("wr_rd_rvalid", rvalid, 4'b0010);
        chk("wr_rd_rdata", rdata, 16'hA5A5);
        cycle('0, 1'b0);

        // Randomized traffic on a small address pool
        max_wait = 0;
        for (int i = 0; i < N; i++) wait_c[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    set_req(i, ($urandom_range(0, 2) == 0), 7'(7'h40 + $urandom_range(0, 3)), 16'($urandom));
                    req[i] = 1'b1;
                end
            end
            cycle('0, 1'b0);
            for (int i = 0; i < N; i++) begin
                if (last_gnt[i]) begin
                    req[i] = 1'b0;
                    wait_c[i] = 0;
                end else if (req[i]) begin
                    wait_c[i]++;
                    if (wait_c[i] > max_wait) max_wait = wait_c[i];
                end
            end
        end
        chk("starve_bound", (max_wait <= N - 1), 1);
        req = '0;
        repeat (3) cycle('0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
